// File: rtl/branch_redirect_ctrl_pkg.sv
// Shared types and default widths for the branch redirect controller.
package branch_redirect_ctrl_pkg;
   localparam int PC_W_DEF  = 9;
   localparam int CNT_W_DEF = 16;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      REDIRECT = 2'd1,
      SETTLE   = 2'd2
   } state_t;
endpackage

// File: rtl/branch_redirect_ctrl_if.sv
// EX-side branch inputs, fetch handshake and pipeline control outputs of the redirect controller.
interface branch_redirect_ctrl_if
   import branch_redirect_ctrl_pkg::*;
#(
   parameter int PC_W  = PC_W_DEF,
   parameter int CNT_W = CNT_W_DEF
);
   logic             ex_branch_valid;
   logic             ex_pc_sel;
   logic [PC_W-1:0]  ex_br_pc;
   logic             hazard_stall;
   logic             fetch_ready;
   logic             redirect_valid;
   logic [PC_W-1:0]  redirect_pc;
   logic             flush_ifid;
   logic             flush_idex;
   logic             pc_hold;
   logic [CNT_W-1:0] branch_count;
   logic [CNT_W-1:0] taken_count;

   modport master (
      output ex_branch_valid, ex_pc_sel, ex_br_pc, hazard_stall, fetch_ready,
      input  redirect_valid, redirect_pc, flush_ifid, flush_idex, pc_hold,
             branch_count, taken_count
   );

   modport slave (
      input  ex_branch_valid, ex_pc_sel, ex_br_pc, hazard_stall, fetch_ready,
      output redirect_valid, redirect_pc, flush_ifid, flush_idex, pc_hold,
             branch_count, taken_count
   );
endinterface

// File: rtl/branch_redirect_ctrl_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc,
   output logic [W-1:0] count
);
   always_ff @(posedge clk) begin
      if (reset)
         count <= '0;
      else if (inc && (count != '1))
         count <= count + 1'b1;
   end
endmodule

// File: rtl/branch_redirect_ctrl.sv
// Sequences the fetch redirect after a taken branch in EX: handshake, wrong-path flushes,
// PC hold under fetch backpressure, and saturating resolve/taken statistics.
module branch_redirect_ctrl
   import branch_redirect_ctrl_pkg::*;
#(
   parameter int PC_W  = PC_W_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic                   clk,
   input  logic                   reset,
   branch_redirect_ctrl_if.slave  bus
);
   localparam logic [PC_W-1:0] ALIGN_MASK = ~PC_W'(1);

   state_t          state, state_nxt;
   logic [PC_W-1:0] target;
   logic            accept, taken;

   // Only IDLE listens to EX; anything seen during a redirect is wrong-path.
   assign accept = (state == IDLE) && bus.ex_branch_valid && !bus.hazard_stall;
   assign taken  = accept && bus.ex_pc_sel;

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         target <= '0;
      end else begin
         state <= state_nxt;
         if (taken)
            target <= bus.ex_br_pc & ALIGN_MASK;
      end
   end

   always_comb begin
      state_nxt          = state;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = '0;
      bus.flush_ifid     = 1'b0;
      bus.flush_idex     = 1'b0;
      bus.pc_hold        = 1'b0;
      unique case (state)
         IDLE: begin
            if (taken)
               state_nxt = REDIRECT;
         end
         REDIRECT: begin
            bus.redirect_valid = 1'b1;
            bus.redirect_pc    = target;
            bus.flush_ifid     = 1'b1;
            bus.flush_idex     = 1'b1;
            bus.pc_hold        = !bus.fetch_ready;
            if (bus.fetch_ready)
               state_nxt = SETTLE;
         end
         SETTLE: begin
            // one extra ID/EX squash catches the instruction fetched before the redirect landed
            bus.flush_idex = 1'b1;
            state_nxt      = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   sat_counter #(.W(CNT_W)) u_branch_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (accept),
      .count (bus.branch_count)
   );

   sat_counter #(.W(CNT_W)) u_taken_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (taken),
      .count (bus.taken_count)
   );
endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Directed vector table plus a saturation sequence on a narrow-counter instance.
module tb_branch_redirect_ctrl;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   branch_redirect_ctrl_if #(.PC_W(9), .CNT_W(16)) bus ();
   branch_redirect_ctrl_if #(.PC_W(9), .CNT_W(4))  bus4 ();

   branch_redirect_ctrl #(.PC_W(9), .CNT_W(16)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   branch_redirect_ctrl #(.PC_W(9), .CNT_W(4)) dut4 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus4)
   );

   typedef struct {
      logic        rst, bv, sel;
      logic [8:0]  pc;
      logic        stall, fr;
      logic        rv;
      logic [8:0]  rpc;
      logic        fi, fe, hold;
      logic [15:0] bc, tc;
   } vec_t;

   localparam int NV = 25;
   vec_t tbl [NV];
   int   n_cmp = 0;
   int   n_err = 0;

   task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s[%0d]: got %0d expected %0d", name, idx, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic rst, bv, sel, input logic [8:0] pc, input logic stall, fr,
                               input logic rv, input logic [8:0] rpc, input logic fi, fe, hold,
                               input logic [15:0] bc, tc);
      vec_t v;
      v.rst = rst; v.bv = bv; v.sel = sel; v.pc = pc; v.stall = stall; v.fr = fr;
      v.rv = rv; v.rpc = rpc; v.fi = fi; v.fe = fe; v.hold = hold; v.bc = bc; v.tc = tc;
      return v;
   endfunction

   task automatic check_out(input int idx, input logic rv, input logic [8:0] rpc, input logic fi, fe, hold,
                            input logic [15:0] bc, tc);
      chk("redirect_valid", idx, 32'(bus.redirect_valid), 32'(rv));
      chk("redirect_pc",    idx, 32'(bus.redirect_pc),    32'(rpc));
      chk("flush_ifid",     idx, 32'(bus.flush_ifid),     32'(fi));
      chk("flush_idex",     idx, 32'(bus.flush_idex),     32'(fe));
      chk("pc_hold",        idx, 32'(bus.pc_hold),        32'(hold));
      chk("branch_count",   idx, 32'(bus.branch_count),   32'(bc));
      chk("taken_count",    idx, 32'(bus.taken_count),    32'(tc));
   endtask

   initial begin
      //            rst bv sel pc   stl fr  | rv rpc fi fe hd bc tc
      // taken to 121: redirect, settle, idle
      tbl[0]  = mk(0, 1, 1, 9'd121, 0, 1,   0, 0,   0, 0, 0, 0, 0);
      tbl[1]  = mk(0, 0, 0, 9'd0,   0, 1,   1, 120, 1, 1, 0, 1, 1);
      tbl[2]  = mk(0, 0, 0, 9'd0,   0, 1,   0, 0,   0, 1, 0, 1, 1);
      tbl[3]  = mk(0, 0, 0, 9'd0,   0, 1,   0, 0,   0, 0, 0, 1, 1);
      // taken to 40 with 3 cycles of backpressure; wrong-path taken in SETTLE
      tbl[4]  = mk(0, 1, 1, 9'd40,  0, 0,   0, 0,   0, 0, 0, 1, 1);
      tbl[5]  = mk(0, 0, 0, 9'd0,   0, 0,   1, 40,  1, 1, 1, 2, 2);
      tbl[6]  = mk(0, 0, 0, 9'd0,   0, 0,   1, 40,  1, 1, 1, 2, 2);
      tbl[7]  = mk(0, 0, 0, 9'd0,   0, 0,   1, 40,  1, 1, 1, 2, 2);
      tbl[8]  = mk(0, 0, 0, 9'd0,   0, 1,   1, 40,  1, 1, 0, 2, 2);
      tbl[9]  = mk(0, 1, 1, 9'd200, 0, 1,   0, 0,   0, 1, 0, 2, 2);
      tbl[10] = mk(0, 0, 0, 9'd0,   0, 1,   0, 0,   0, 0, 0, 2, 2);
      // stalled taken branch, then released as not-taken: counted once
      tbl[11] = mk(0, 1, 1, 9'd60,  1, 1,   0, 0,   0, 0, 0, 2, 2);
      tbl[12] = mk(0, 1, 1, 9'd60,  1, 1,   0, 0,   0, 0, 0, 2, 2);
      tbl[13] = mk(0, 1, 0, 9'd60,  0, 1,   0, 0,   0, 0, 0, 2, 2);
      tbl[14] = mk(0, 0, 0, 9'd0,   0, 1,   0, 0,   0, 0, 0, 3, 2);
      // taken to 77, wrong-path takens in REDIRECT and SETTLE ignored
      tbl[15] = mk(0, 1, 1, 9'd77,  0, 0,   0, 0,   0, 0, 0, 3, 2);
      tbl[16] = mk(0, 1, 1, 9'd300, 0, 0,   1, 76,  1, 1, 1, 4, 3);
      tbl[17] = mk(0, 1, 1, 9'd301, 0, 1,   1, 76,  1, 1, 0, 4, 3);
      tbl[18] = mk(0, 1, 1, 9'd302, 0, 1,   0, 0,   0, 1, 0, 4, 3);
      tbl[19] = mk(0, 0, 0, 9'd0,   0, 1,   0, 0,   0, 0, 0, 4, 3);
      // max target 511 aligns to 510; reset while held in REDIRECT
      tbl[20] = mk(0, 1, 1, 9'd511, 0, 0,   0, 0,   0, 0, 0, 4, 3);
      tbl[21] = mk(0, 0, 0, 9'd0,   0, 0,   1, 510, 1, 1, 1, 5, 4);
      tbl[22] = mk(1, 0, 0, 9'd0,   0, 0,   1, 510, 1, 1, 1, 5, 4);
      tbl[23] = mk(0, 0, 0, 9'd0,   0, 1,   0, 0,   0, 0, 0, 0, 0);
      tbl[24] = mk(0, 0, 0, 9'd0,   0, 1,   0, 0,   0, 0, 0, 0, 0);

      reset = 1'b1;
      bus.ex_branch_valid = 0; bus.ex_pc_sel = 0; bus.ex_br_pc = '0; bus.hazard_stall = 0; bus.fetch_ready = 0;
      bus4.ex_branch_valid = 0; bus4.ex_pc_sel = 0; bus4.ex_br_pc = '0; bus4.hazard_stall = 0; bus4.fetch_ready = 0;
      @(posedge clk); #1;
      reset = 1'b0;
      check_out(-1, 0, 0, 0, 0, 0, 0, 0);

      for (int i = 0; i < NV; i++) begin
         reset               = tbl[i].rst;
         bus.ex_branch_valid = tbl[i].bv;
         bus.ex_pc_sel       = tbl[i].sel;
         bus.ex_br_pc        = tbl[i].pc;
         bus.hazard_stall    = tbl[i].stall;
         bus.fetch_ready     = tbl[i].fr;
         #1;
         check_out(i, tbl[i].rv, tbl[i].rpc, tbl[i].fi, tbl[i].fe, tbl[i].hold, tbl[i].bc, tbl[i].tc);
         @(posedge clk); #1;
      end
      reset = 1'b0;

      // 20 fully handshaken taken branches on the 4-bit-counter instance
      for (int i = 0; i < 20; i++) begin
         int cyc;
         int exp_cnt;
         bus4.ex_branch_valid = 1; bus4.ex_pc_sel = 1; bus4.ex_br_pc = 9'(i * 2); bus4.fetch_ready = 0;
         @(posedge clk); #1;
         bus4.ex_branch_valid = 0; bus4.ex_pc_sel = 0;
         cyc = 0;
         while (!bus4.redirect_valid && cyc < 5) begin
            @(posedge clk); #1;
            cyc++;
         end
         chk("sat_redirect_valid", i, 32'(bus4.redirect_valid), 32'd1);
         chk("sat_redirect_pc",    i, 32'(bus4.redirect_pc),    32'(i * 2));
         bus4.fetch_ready = 1;
         @(posedge clk); #1;
         bus4.fetch_ready = 0;
         @(posedge clk); #1;
         exp_cnt = (i + 1 > 15) ? 15 : i + 1;
         chk("sat_branch_count", i, 32'(bus4.branch_count), 32'(exp_cnt));
         chk("sat_taken_count",  i, 32'(bus4.taken_count),  32'(exp_cnt));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/branch_redirect_ctrl.md
Name: branch_redirect_ctrl

Overview:
- Sequences the PC redirect that follows a branch or jump resolved in EX.
- Consumes the branch unit's taken decision (PcSel) and target (BrPC), then hands the target to fetch with a valid/ready handshake.
- Flushes the wrong-path IF/ID and ID/EX registers and holds the PC while fetch applies backpressure.
- Keeps saturating statistics counters for resolved and taken branches.

Parameters:
- PC_W, 9, width of the PC and branch target in bits (same as the branch unit's PC width).
- CNT_W, 16, width of each statistics counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous reset, active-high.
- ex_branch_valid  in  1  a real (non-bubble) branch or jump instruction is in EX this cycle.
- ex_pc_sel  in  1  PcSel from the branch unit: 1 = taken.
- ex_br_pc  in  PC_W  BrPC from the branch unit: the target address.
- hazard_stall  in  1  load-use stall from the hazard unit; EX contents are not final this cycle.
- fetch_ready  in  1  fetch stage accepts the redirect this cycle.
- redirect_valid  out  1  redirect request to fetch.
- redirect_pc  out  PC_W  redirect target.
- flush_ifid  out  1  squash the IF/ID register.
- flush_idex  out  1  squash the ID/EX register.
- pc_hold  out  1  freeze the PC register.
- branch_count  out  CNT_W  number of resolved branches and jumps.
- taken_count  out  CNT_W  number of taken branches and jumps.

Behaviour:
- All state is registered on the rising edge of clk.
- reset is synchronous and active-high. At the first edge with reset=1:
  - state goes to IDLE;
  - both counters and the latched target clear to 0;
  - therefore every output is 0.
- Reset mid-REDIRECT or mid-SETTLE drops the request without a handshake.
- A branch qualifies ("accepted") when all of these hold: state==IDLE, ex_branch_valid=1 and hazard_stall=0.
- Resolve event: on an accepted branch, branch_count increments.
- Taken event: if the accepted branch also has ex_pc_sel=1, then:
  - taken_count increments;
  - the target latches as {ex_br_pc[PC_W-1:1],1'b0}, so bit 0 is always forced to 0;
  - state goes to REDIRECT.
- Not-taken accepted branch: branch_count increments only; the outputs do not change.
- Counters saturate at all-ones and never wrap.
- Latency: taken detected at edge N, so redirect_valid, flush_ifid and flush_idex are high in the cycle after edge N.
- IDLE:
  - all control outputs are 0;
  - a taken event moves the block to REDIRECT.
- REDIRECT:
  - redirect_valid=1; redirect_pc = latched target, stable until the handshake;
  - flush_ifid=1 and flush_idex=1 in every REDIRECT cycle;
  - pc_hold = ~fetch_ready;
  - on redirect_valid && fetch_ready the block moves to SETTLE.
- SETTLE:
  - lasts exactly one cycle and then returns to IDLE;
  - flush_idex=1 to kill the last wrong-path instruction; all other controls are 0.
- In REDIRECT and SETTLE, ex_branch_valid, ex_pc_sel and hazard_stall are ignored: the instruction in EX is wrong-path, so neither counter changes.
- hazard_stall=1 in IDLE blocks acceptance. The same branch is re-presented and counted once, after the stall clears.
- redirect_pc reads 0 whenever redirect_valid=0.

Decomposition:
- Shared package holds:
  - the state enum {IDLE, REDIRECT, SETTLE} (2 bits);
  - the default widths PC_W_DEF=9 and CNT_W_DEF=16.
- One natural sub-module: sat_counter (parameter W; inputs clk, reset, inc; output count). It is instantiated twice.

Test Plan:
- Taken redirect with PC_W=9: IDLE, ex_branch_valid=1, ex_pc_sel=1, ex_br_pc=9'd121, fetch_ready=1 at edge N.
  - Cycle N+1: redirect_valid=1, redirect_pc=9'd120, both flushes =1, pc_hold=0.
  - Cycle N+2: SETTLE, flush_idex=1 only.
  - Cycle N+3: IDLE; taken_count=1, branch_count=1.
- Fetch backpressure: taken to 9'd40 with fetch_ready=0 for 3 cycles, then 1.
  - redirect_valid and both flushes are high for 4 cycles.
  - pc_hold is high for the first 3 of those cycles; redirect_pc=9'd40 throughout.
- Stall and not-taken: hazard_stall=1 with a taken branch for 2 cycles, then released with ex_pc_sel=0.
  - No redirect occurs.
  - branch_count=1 and taken_count=0, i.e. counted once, only after the stall clears.
- Wrong-path ignore: a second taken branch presented during REDIRECT and during SETTLE.
  - No second redirect; taken_count stays 1.
- Saturation with CNT_W=4: 20 taken branches, each fully handshaken.
  - taken_count=4'd15 and branch_count=4'd15.
- Reset mid-operation: reset=1 for one edge while in REDIRECT with fetch_ready=0.
  - After that edge: all outputs 0, state IDLE, counters 0.
